// File: rtl/rs_syndrome_buffer_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the RS syndrome buffer.
package rs_pkg;

    localparam int         SYM_W             = 8;
    localparam logic [8:0] PRIM_POLY_DEFAULT = 9'h11D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_OUTPUT
    } state_e;

    // Multiply by alpha (0x02) with reduction by the field polynomial.
    function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] a,
                                                  input logic [8:0]       poly);
        logic [8:0] t;
        t = {a, 1'b0};
        if (t[8]) begin
            t = t ^ poly;
        end
        return t[SYM_W-1:0];
    endfunction

    // Constant alpha^j, evaluated at elaboration time for the syndrome multipliers.
    function automatic logic [SYM_W-1:0] gf_pow_alpha(input int         j,
                                                      input logic [8:0] poly = PRIM_POLY_DEFAULT);
        logic [SYM_W-1:0] r;
        r = 8'h01;
        for (int k = 0; k < j; k++) begin
            r = gf_xtime(r, poly);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_syndrome_buffer_if.sv
// Symbol-in / symbol-out stream plus status bus of the RS syndrome buffer.
interface rs_syndrome_buffer_if #(
    parameter int NSYM = 7
);
    import rs_pkg::*;

    logic                   start;
    logic [SYM_W-1:0]       codeword_in;
    logic                   valid_in;
    logic                   last_in;
    logic                   in_ready;
    logic [SYM_W-1:0]       codeword_out;
    logic                   valid_out;
    logic                   last_out;
    logic                   out_ready;
    logic [NSYM*SYM_W-1:0]  syndromes;
    logic                   err_detected;
    logic                   overflow;
    logic [7:0]             frame_len;
    logic                   done;

    // Producer/consumer side.
    modport master (
        output start, codeword_in, valid_in, last_in, out_ready,
        input  in_ready, codeword_out, valid_out, last_out,
               syndromes, err_detected, overflow, frame_len, done
    );

    // Buffer side.
    modport slave (
        input  start, codeword_in, valid_in, last_in, out_ready,
        output in_ready, codeword_out, valid_out, last_out,
               syndromes, err_detected, overflow, frame_len, done
    );

endinterface

// File: rtl/rs_syndrome_buffer_gf_mul.sv
// Combinational GF(2^8) multiplier: carry-less product reduced by PRIM_POLY.
module gf_mul
    import rs_pkg::*;
#(
    parameter logic [8:0] PRIM_POLY = PRIM_POLY_DEFAULT
) (
    input  logic [SYM_W-1:0] a_i,
    input  logic [SYM_W-1:0] b_i,
    output logic [SYM_W-1:0] p_o
);

    // MSB-first shift-and-add: acc = acc*alpha, then add a when the b bit is set.
    always_comb begin
        logic [SYM_W-1:0] acc;
        acc = '0;
        for (int i = SYM_W - 1; i >= 0; i--) begin
            acc = gf_xtime(acc, PRIM_POLY);
            if (b_i[i]) begin
                acc = acc ^ a_i;
            end
        end
        p_o = acc;
    end

endmodule

// File: rtl/rs_syndrome_buffer.sv
// Stores one RS codeword frame, computes NSYM syndromes on the fly (Horner,
// fcr = 0, alpha = 0x02), flags nonzero syndromes and replays the frame.
module rs_syndrome_buffer
    import rs_pkg::*;
#(
    parameter int         NSYM      = 7,
    parameter int         MAX_CW    = 32,
    parameter logic [8:0] PRIM_POLY = PRIM_POLY_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    rs_syndrome_buffer_if.slave bus
);

    localparam int         AW        = (MAX_CW > 1) ? $clog2(MAX_CW) : 1;
    localparam logic [7:0] MAX_CW_U8 = 8'(MAX_CW);

    state_e           state_q, state_d;
    logic [7:0]       wr_idx_q, wr_idx_d;
    logic [7:0]       rd_idx_q, rd_idx_d;
    logic [7:0]       frame_len_q, frame_len_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [SYM_W-1:0] synd_q   [NSYM];
    logic [SYM_W-1:0] synd_d   [NSYM];
    logic [SYM_W-1:0] synd_mul [NSYM];
    logic [SYM_W-1:0] buf_q    [MAX_CW];

    logic                  in_accept;
    logic                  out_accept;
    logic                  buf_we;
    logic                  last_beat;
    logic                  any_synd;
    logic [NSYM*SYM_W-1:0] synd_flat;

    // One multiplier per syndrome, each by its own constant alpha^j.
    for (genvar j = 0; j < NSYM; j++) begin : g_synd
        localparam logic [SYM_W-1:0] ALPHA_J = gf_pow_alpha(j, PRIM_POLY);
        gf_mul #(.PRIM_POLY(PRIM_POLY)) u_mul (
            .a_i (synd_q[j]),
            .b_i (ALPHA_J),
            .p_o (synd_mul[j])
        );
    end

    // Flatten syndromes onto the bus and reduce them to a single error flag.
    always_comb begin
        synd_flat = '0;
        any_synd  = 1'b0;
        for (int j = 0; j < NSYM; j++) begin
            synd_flat[j*SYM_W +: SYM_W] = synd_q[j];
            any_synd                    = any_synd | (|synd_q[j]);
        end
    end

    assign in_accept  = (state_q == ST_LOAD) && bus.valid_in;
    assign out_accept = (state_q == ST_OUTPUT) && bus.out_ready;
    assign last_beat  = (rd_idx_q == frame_len_q - 8'd1);

    // Next-state and datapath update for the load/check/replay sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        frame_len_d = frame_len_q;
        overflow_d  = overflow_q;
        err_d       = err_q;
        done_d      = 1'b0;
        synd_d      = synd_q;
        buf_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_LOAD;
                    wr_idx_d    = '0;
                    frame_len_d = '0;
                    overflow_d  = 1'b0;
                    err_d       = 1'b0;
                    for (int j = 0; j < NSYM; j++) begin
                        synd_d[j] = '0;
                    end
                end
            end
            ST_LOAD: begin
                if (in_accept) begin
                    // Dropped symbols still enter the syndromes so the error flag sees them.
                    for (int j = 0; j < NSYM; j++) begin
                        synd_d[j] = synd_mul[j] ^ bus.codeword_in;
                    end
                    if (wr_idx_q < MAX_CW_U8) begin
                        buf_we   = 1'b1;
                        wr_idx_d = wr_idx_q + 8'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (bus.last_in) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                frame_len_d = wr_idx_q;
                err_d       = any_synd;
                rd_idx_d    = '0;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_accept) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, flags and syndrome registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            frame_len_q <= '0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            for (int j = 0; j < NSYM; j++) begin
                synd_q[j] <= '0;
            end
        end else begin
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            frame_len_q <= frame_len_d;
            overflow_q  <= overflow_d;
            err_q       <= err_d;
            done_q      <= done_d;
            synd_q      <= synd_d;
        end
    end

    // Symbol store.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is not reset; it is only read after being written in the same frame.
        if (buf_we) begin
            buf_q[wr_idx_q[AW-1:0]] <= bus.codeword_in;
        end
    end

    assign bus.in_ready     = (state_q == ST_LOAD);
    assign bus.valid_out    = (state_q == ST_OUTPUT);
    assign bus.codeword_out = (state_q == ST_OUTPUT) ? buf_q[rd_idx_q[AW-1:0]] : '0;
    assign bus.last_out     = (state_q == ST_OUTPUT) && last_beat;
    assign bus.syndromes    = synd_flat;
    assign bus.err_detected = err_q;
    assign bus.overflow     = overflow_q;
    assign bus.frame_len    = frame_len_q;
    assign bus.done         = done_q;

endmodule
